// File: rtl/hog_pkg.sv
// Shared defaults and width helpers for the HOG front-end blocks (line buffer reader side).
package hog_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int KERNEL_WIDTH  = 3;
    localparam int IMG_WIDTH     = 854;
    localparam int COL_WIDTH     = DATA_WIDTH * KERNEL_WIDTH;
    localparam int WIN_WIDTH     = COL_WIDTH * KERNEL_WIDTH;
    localparam int COL_CNT_WIDTH = $clog2(IMG_WIDTH);

    // Counter width for a modulus n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/window_shift_reg.sv
// K-column shift register holding the sliding window; column 0 is the oldest column.
module window_shift_reg #(
    parameter int DATA_WIDTH   = hog_pkg::DATA_WIDTH,
    parameter int KERNEL_WIDTH = hog_pkg::KERNEL_WIDTH
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        load,
    input  logic [KERNEL_WIDTH*DATA_WIDTH-1:0]          col_data,
    output logic [KERNEL_WIDTH*KERNEL_WIDTH*DATA_WIDTH-1:0] win_data
);

    localparam int COL_W = KERNEL_WIDTH * DATA_WIDTH;

    logic [COL_W-1:0] cols [KERNEL_WIDTH];

    // NOTE: this small register array is reset on purpose because win_data must read zero after
    // reset; a large RAM-backed buffer would normally be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < KERNEL_WIDTH; c++) cols[c] <= '0;
        end else if (load) begin
            // NOTE: non-blocking assignments let every column read its neighbour's old value,
            // so the shift is order-independent.
            for (int c = 0; c < KERNEL_WIDTH - 1; c++) cols[c] <= cols[c+1];
            cols[KERNEL_WIDTH-1] <= col_data;
        end
    end

    for (genvar r = 0; r < KERNEL_WIDTH; r++) begin : g_row
        for (genvar c = 0; c < KERNEL_WIDTH; c++) begin : g_col
            assign win_data[(r*KERNEL_WIDTH+c)*DATA_WIDTH +: DATA_WIDTH] = cols[c][r*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/kernel_window_builder.sv
// Builds KxK sliding windows from line-buffer columns, tagging border and end-of-row.
// Optional macro KWB_BORDER_DROP_EN: border windows are consumed internally and never presented.
module kernel_window_builder #(
    parameter int DATA_WIDTH   = hog_pkg::DATA_WIDTH,
    parameter int KERNEL_WIDTH = hog_pkg::KERNEL_WIDTH,
    parameter int IMG_WIDTH    = hog_pkg::IMG_WIDTH
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic [KERNEL_WIDTH*DATA_WIDTH-1:0]              col_data,
    input  logic                                            col_valid,
    input  logic                                            col_border,
    output logic                                            col_ready,
    output logic [KERNEL_WIDTH*KERNEL_WIDTH*DATA_WIDTH-1:0] win_data,
    output logic                                            win_valid,
    output logic                                            win_border,
    output logic                                            win_eol,
    input  logic                                            win_ready
);

    import hog_pkg::*;

    localparam int CNT_W  = cnt_width(IMG_WIDTH);
    localparam int FILL_W = cnt_width(KERNEL_WIDTH);

    logic [CNT_W-1:0]  col_cnt;
    logic [FILL_W-1:0] fill_cnt;
    logic              accept;
    logic              full;
    logic              last_col;
    logic              present;
    logic              border_next;

    assign col_ready = ~win_valid | win_ready;
    assign accept    = col_valid & col_ready;
    assign full      = (fill_cnt == FILL_W'(KERNEL_WIDTH - 1));
    assign last_col  = (col_cnt == CNT_W'(IMG_WIDTH - 1));

`ifdef KWB_BORDER_DROP_EN
    assign present     = ~col_border;
    assign border_next = 1'b0;
`else
    assign present     = 1'b1;
    assign border_next = col_border;
`endif

    window_shift_reg #(
        .DATA_WIDTH   (DATA_WIDTH),
        .KERNEL_WIDTH (KERNEL_WIDTH)
    ) u_shift (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .col_data (col_data),
        .win_data (win_data)
    );

    // fill_cnt survives the row wrap: straddling windows are flagged by the line buffer instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt    <= '0;
            fill_cnt   <= '0;
            win_valid  <= 1'b0;
            win_border <= 1'b0;
            win_eol    <= 1'b0;
        end else if (accept) begin
            col_cnt    <= last_col ? '0 : col_cnt + 1'b1;
            if (!full) fill_cnt <= fill_cnt + 1'b1;
            win_valid  <= full & present;
            win_border <= border_next;
            win_eol    <= last_col;
        end else if (win_ready) begin
            win_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_kernel_window_builder.sv
// Scoreboard bench for kernel_window_builder (DW=8, K=3, IMG_WIDTH=6), directed and random traffic.
module tb_kernel_window_builder;

    localparam int DW = 8;
    localparam int K  = 3;
    localparam int IW = 6;
    localparam int CW = DW * K;
    localparam int WW = CW * K;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] col_data = '0;
    logic          col_valid = 1'b0;
    logic          col_border = 1'b0;
    logic          win_ready = 1'b1;
    logic          col_ready;
    logic [WW-1:0] win_data;
    logic          win_valid;
    logic          win_border;
    logic          win_eol;

    kernel_window_builder #(
        .DATA_WIDTH   (DW),
        .KERNEL_WIDTH (K),
        .IMG_WIDTH    (IW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .col_data   (col_data),
        .col_valid  (col_valid),
        .col_border (col_border),
        .col_ready  (col_ready),
        .win_data   (win_data),
        .win_valid  (win_valid),
        .win_border (win_border),
        .win_eol    (win_eol),
        .win_ready  (win_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WW-1:0] data;
        logic          border;
        logic          eol;
    } win_t;

    win_t          exp_q[$];
    logic [CW-1:0] hist[$];
    int            nacc = 0;
    int            n_vec = 0;
    int            n_err = 0;
    int            win_seen = 0;
    int            eol_seen = 0;
    int            border_seen = 0;
    bit            rnd_done = 1'b0;

    task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the window is simply the last K accepted columns since reset.
    always @(negedge clk) begin
        win_t w;
        int   idx;
        if (rst_n && col_valid && col_ready) begin
            hist.push_back(col_data);
            if (hist.size() > K) void'(hist.pop_front());
            idx  = nacc;
            nacc = nacc + 1;
            if (hist.size() == K) begin
                w.data = '0;
                for (int r = 0; r < K; r++)
                    for (int c = 0; c < K; c++)
                        w.data[(r*K+c)*DW +: DW] = hist[c][r*DW +: DW];
                w.eol = ((idx % IW) == IW - 1);
`ifdef KWB_BORDER_DROP_EN
                w.border = 1'b0;
                if (!col_border) exp_q.push_back(w);
`else
                w.border = col_border;
                exp_q.push_back(w);
`endif
            end
        end
    end

    // Monitor: a window handshake occurs at the coming posedge; inputs are stable here.
    always @(negedge clk) begin
        win_t e;
        if (rst_n && win_valid && win_ready) begin
            win_seen++;
            if (win_eol) eol_seen++;
            if (win_border) border_seen++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_window: got %0h expected none", win_data);
            end else begin
                e = exp_q.pop_front();
                check("win_data", win_data, e.data);
                check("win_border", WW'(win_border), WW'(e.border));
                check("win_eol", WW'(win_eol), WW'(e.eol));
            end
        end
    end

    function automatic logic [CW-1:0] mk_col(input int a, input int b, input int c);
        return {8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic send_col(input logic [CW-1:0] d, input logic b);
        int budget = 200;
        col_data   = d;
        col_border = b;
        col_valid  = 1'b1;
        while (budget > 0) begin
            @(negedge clk);
            if (col_ready) break;
            budget--;
        end
        if (budget == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL col_accept_timeout: got col_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
        col_valid  = 1'b0;
        col_border = 1'b0;
    endtask

    task automatic clear_model();
        exp_q.delete();
        hist.delete();
        nacc = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        col_valid = 1'b0;
        rst_n     = 1'b0;
        clear_model();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int budget = 500;
        win_ready = 1'b1;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0, e0, b0;

        // Reset state
        do_reset();
        check("reset_win_valid", WW'(win_valid), '0);
        check("reset_win_data", win_data, '0);
        check("reset_win_eol", WW'(win_eol), '0);
        check("reset_win_border", WW'(win_border), '0);
        check("reset_col_ready", WW'(col_ready), WW'(1));

        // First window from three back-to-back columns
        send_col(mk_col(1, 2, 3), 1'b0);
        check("fill1_no_valid", WW'(win_valid), '0);
        send_col(mk_col(4, 5, 6), 1'b0);
        check("fill2_no_valid", WW'(win_valid), '0);
        send_col(mk_col(7, 8, 9), 1'b0);
        check("first_win_valid", WW'(win_valid), WW'(1));
        check("first_win_data", win_data, WW'({8'd9, 8'd6, 8'd3, 8'd8, 8'd5, 8'd2, 8'd7, 8'd4, 8'd1}));
        @(posedge clk);
        #1;
        check("first_win_pulse", WW'(win_valid), '0);
        drain();

        // Twelve-column stream across two rows, border on columns 6 and 7
        do_reset();
        s0 = win_seen;
        e0 = eol_seen;
        b0 = border_seen;
        for (int i = 0; i < 12; i++)
            send_col(CW'($urandom), (i == 6) || (i == 7));
        drain();
`ifdef KWB_BORDER_DROP_EN
        check("stream_win_count", WW'(win_seen - s0), WW'(8));
        check("stream_border_count", WW'(border_seen - b0), WW'(0));
`else
        check("stream_win_count", WW'(win_seen - s0), WW'(10));
        check("stream_border_count", WW'(border_seen - b0), WW'(2));
`endif
        check("stream_eol_count", WW'(eol_seen - e0), WW'(2));

        // Backpressure: downstream stalls four cycles while a column waits
        for (int i = 0; i < 3; i++) send_col(CW'($urandom), 1'b0);
        win_ready = 1'b0;
        fork
            send_col(CW'($urandom), 1'b0);
            begin
                repeat (4) begin
                    @(negedge clk);
                    check("stall_col_ready", WW'(col_ready), '0);
                    check("stall_win_valid", WW'(win_valid), WW'(1));
                    if (exp_q.size() > 0) check("stall_win_data", win_data, exp_q[0].data);
                end
                @(posedge clk);
                #1;
                win_ready = 1'b1;
            end
        join
        check("no_bubble_win_valid", WW'(win_valid), WW'(1));
        drain();

        // Reset mid-row with a window pending
        do_reset();
        for (int i = 0; i < 8; i++) send_col(CW'($urandom), 1'b0);
        check("pre_reset_win_valid", WW'(win_valid), WW'(1));
        rst_n = 1'b0;
        clear_model();
        #1;
        check("midreset_win_valid", WW'(win_valid), '0);
        check("midreset_win_data", win_data, '0);
        check("midreset_win_eol", WW'(win_eol), '0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            send_col(CW'($urandom), 1'b0);
            if (i < 2) check("refill_no_valid", WW'(win_valid), '0);
            if (i == 2) check("refill_win_valid", WW'(win_valid), WW'(1));
            if (i == 5) check("refill_eol", WW'(win_eol), WW'(1));
        end
        drain();

        // Random handshakes on both sides
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    send_col(CW'($urandom), ($urandom_range(0, 4) == 0));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    if (!rnd_done) win_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();
        check("final_queue_empty", WW'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
